// File: rtl/irq_sequencer.sv
// Vectored, priority-nesting user-interrupt controller for the single-cycle core.
// Latches request edges, holds enable bits and a return-PC stack popped by uret.
module irq_sequencer #(
  parameter int unsigned     NUM_IRQ  = 3,
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] VEC_BASE = PC_W'(32'h0000_1000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               instr_done,
  input  logic [PC_W-1:0]    pc_next,
  input  logic               uret,
  input  logic               csrrsi,
  input  logic               csrrci,
  input  logic [NUM_IRQ-1:0] csr_zimm,
  output logic               irq_take,
  output logic [PC_W-1:0]    irq_vector,
  output logic [PC_W-1:0]    epc,
  output logic [NUM_IRQ-1:0] ie,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] in_service
);

  localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned SpW  = $clog2(NUM_IRQ + 1);

  typedef enum logic [0:0] {StRun, StTake} state_e;

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  ie_q, ie_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  in_service_q, in_service_d;
  logic [NUM_IRQ-1:0]  irq_prev_q, irq_prev_d;
  logic [PC_W-1:0]     stack_q [NUM_IRQ];
  logic [PC_W-1:0]     stack_d [NUM_IRQ];
  logic [SpW-1:0]      sp_q, sp_d;
  logic [PC_W-1:0]     irq_vector_q, irq_vector_d;

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  take_mask;
  logic [NUM_IRQ-1:0]  top_svc;
  logic                boundary;
  logic                blocked;
  logic                cand_valid;
  logic [IdxW-1:0]     cand_idx;

  always_comb begin
    rise       = irq_in & ~irq_prev_q;
    irq_prev_d = irq_in;
    // The redirect cycle is not a boundary: the retiring instruction is discarded.
    boundary   = instr_done & (state_q == StRun);

    // Scan from the top; anything at or below the current service level is blocked.
    blocked    = 1'b0;
    cand_valid = 1'b0;
    cand_idx   = '0;
    top_svc    = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (in_service_q[i] && !blocked) begin
        top_svc[i] = 1'b1;
      end
      if (in_service_q[i]) begin
        blocked = 1'b1;
      end
      if (!blocked && !cand_valid && pending_q[i] && ie_q[i]) begin
        cand_valid = 1'b1;
        cand_idx   = IdxW'(i);
      end
    end

    state_d      = StRun;
    ie_d         = ie_q;
    in_service_d = in_service_q;
    sp_d         = sp_q;
    stack_d      = stack_q;
    irq_vector_d = irq_vector_q;
    take_mask    = '0;

    if (boundary) begin
      if (uret) begin
        if (sp_q != '0) begin
          sp_d         = sp_q - SpW'(1);
          in_service_d = in_service_q & ~top_svc;
        end
      end else if (cand_valid) begin
        take_mask[cand_idx] = 1'b1;
        in_service_d        = in_service_q | take_mask;
        stack_d[sp_q]       = pc_next;
        sp_d                = sp_q + SpW'(1);
        irq_vector_d        = VEC_BASE + (PC_W'(cand_idx) << 2);
        state_d             = StTake;
      end
      // Take above used the old ie; clear beats set when both are decoded.
      if (csrrci) begin
        ie_d = ie_q & ~csr_zimm;
      end else if (csrrsi) begin
        ie_d = ie_q | csr_zimm;
      end
    end

    // A fresh edge on the source being taken survives for a second service.
    pending_d = (pending_q & ~take_mask) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      ie_q         <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      irq_prev_q   <= '0;
      sp_q         <= '0;
      irq_vector_q <= '0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ie_q         <= ie_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      irq_prev_q   <= irq_prev_d;
      sp_q         <= sp_d;
      irq_vector_q <= irq_vector_d;
      stack_q      <= stack_d;
    end
  end

  assign irq_take   = (state_q == StTake);
  assign irq_vector = irq_vector_q;
  assign epc        = (sp_q == '0) ? '0 : stack_q[sp_q - SpW'(1)];
  assign ie         = ie_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios then random traffic, all checked
// against a queue-based model of the service stack.
module tb_irq_sequencer;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  irq_in = '0;
  logic          instr_done = 1'b0;
  logic [31:0]   pc_next = '0;
  logic          uret = 1'b0;
  logic          csrrsi = 1'b0;
  logic          csrrci = 1'b0;
  logic [N-1:0]  csr_zimm = '0;
  logic          irq_take;
  logic [31:0]   irq_vector;
  logic [31:0]   epc;
  logic [N-1:0]  ie;
  logic [N-1:0]  pending;
  logic [N-1:0]  in_service;

  irq_sequencer #(
    .NUM_IRQ  (N),
    .PC_W     (32),
    .VEC_BASE (32'h0000_1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .instr_done (instr_done),
    .pc_next    (pc_next),
    .uret       (uret),
    .csrrsi     (csrrsi),
    .csrrci     (csrrci),
    .csr_zimm   (csr_zimm),
    .irq_take   (irq_take),
    .irq_vector (irq_vector),
    .epc        (epc),
    .ie         (ie),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Model: services are a stack of source numbers with their return PCs.
  bit          m_pend [N];
  bit          m_ie   [N];
  bit          m_prev [N];
  int          m_svc  [$];
  logic [31:0] m_pcs  [$];
  bit          m_take;
  logic [31:0] m_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [N-1:0] pack(input bit a [N]);
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic logic [N-1:0] svc_bits();
    logic [N-1:0] v = '0;
    foreach (m_svc[k]) v[m_svc[k]] = 1'b1;
    return v;
  endfunction

  task automatic model_edge();
    int  lvl;
    int  cand;
    bit  bnd;
    bit  nt;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_ie[i] = 0; m_prev[i] = 0;
      end
      m_svc.delete();
      m_pcs.delete();
      m_take = 0;
      m_vec  = '0;
      return;
    end
    bnd  = instr_done && !m_take;
    nt   = 0;
    lvl  = (m_svc.size() == 0) ? -1 : m_svc[$];
    if (bnd && uret) begin
      if (m_svc.size() > 0) begin
        void'(m_svc.pop_back());
        void'(m_pcs.pop_back());
      end
    end else if (bnd) begin
      cand = -1;
      for (int i = N - 1; i > lvl; i--)
        if (cand < 0 && m_pend[i] && m_ie[i]) cand = i;
      if (cand >= 0) begin
        m_pend[cand] = 0;
        m_svc.push_back(cand);
        m_pcs.push_back(pc_next);
        m_vec = 32'h1000 + 32'(4 * cand);
        nt = 1;
      end
    end
    if (bnd) begin
      for (int i = 0; i < N; i++)
        if (csr_zimm[i]) begin
          if (csrrci) m_ie[i] = 0;
          else if (csrrsi) m_ie[i] = 1;
        end
    end
    for (int i = 0; i < N; i++) begin
      if (irq_in[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev[i] = irq_in[i];
    end
    m_take = nt;
  endtask

  task automatic check_all();
    chk("irq_take", 32'(irq_take), 32'(m_take));
    if (m_take) chk("irq_vector", irq_vector, m_vec);
    chk("epc", epc, (m_pcs.size() == 0) ? 32'h0 : m_pcs[$]);
    chk("ie", 32'(ie), 32'(pack(m_ie)));
    chk("pending", 32'(pending), 32'(pack(m_pend)));
    chk("in_service", 32'(in_service), 32'(svc_bits()));
  endtask

  task automatic cyc(input logic [N-1:0] irq, input bit done, input logic [31:0] pc,
                     input bit ur, input bit si, input bit ci, input logic [N-1:0] z,
                     input bit r);
    @(negedge clk);
    irq_in = irq; instr_done = done; pc_next = pc; uret = ur;
    csrrsi = si; csrrci = ci; csr_zimm = z; rst = r;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic idle(input logic [N-1:0] irq);
    cyc(irq, 0, 32'h0, 0, 0, 0, 3'b000, 0);
  endtask

  task automatic step(input logic [N-1:0] irq, input logic [31:0] pc);
    cyc(irq, 1, pc, 0, 0, 0, 3'b000, 0);
  endtask

  task automatic ret(input logic [N-1:0] irq);
    cyc(irq, 1, 32'h0, 1, 0, 0, 3'b000, 0);
  endtask

  initial begin
    logic [N-1:0] cur_irq;

    // Plan 1: capture regardless of ie, enable then take.
    cyc(3'b000, 0, 0, 0, 0, 0, 3'b000, 1);
    cyc(3'b000, 0, 0, 0, 0, 0, 3'b000, 1);
    chk("reset_in_service", 32'(in_service), 32'h0);
    idle(3'b001);
    chk("tp1_pending", 32'(pending), 32'h1);
    cyc(3'b001, 1, 32'h100, 0, 1, 0, 3'b001, 0);
    chk("tp1_no_take_on_enable", 32'(irq_take), 32'h0);
    step(3'b001, 32'h200);
    chk("tp1_vec", irq_vector, 32'h1000);
    chk("tp1_epc", epc, 32'h200);
    idle(3'b001);

    // Plan 2: nest irq2 over irq0, then unwind.
    cyc(3'b001, 1, 32'h1004, 0, 1, 0, 3'b100, 0);
    idle(3'b101);
    step(3'b101, 32'h1010);
    chk("tp2_vec", irq_vector, 32'h1008);
    chk("tp2_svc", 32'(in_service), 32'h5);
    idle(3'b101);
    ret(3'b101);
    chk("tp2_epc_after_ret", epc, 32'h200);
    ret(3'b000);
    chk("tp2_epc_empty", epc, 32'h0);
    ret(3'b000);

    // Plan 3: lower priority waits behind irq2, tail-chains after uret.
    cyc(3'b000, 1, 32'h300, 0, 1, 0, 3'b010, 0);
    idle(3'b100);
    step(3'b100, 32'h400);
    idle(3'b100);
    idle(3'b110);
    for (int k = 0; k < 5; k++) step(3'b110, 32'h1008 + 32'(4 * k));
    ret(3'b110);
    step(3'b110, 32'h500);
    chk("tp3_vec", irq_vector, 32'h1004);
    idle(3'b000);
    ret(3'b000);

    // Plan 4: simultaneous rise, higher index first.
    idle(3'b110);
    step(3'b110, 32'h600);
    chk("tp4_vec", irq_vector, 32'h1008);
    idle(3'b110);
    step(3'b110, 32'h1008);
    ret(3'b000);
    step(3'b000, 32'h700);
    idle(3'b000);
    ret(3'b000);

    // Plan 5: set and clear together, clear wins.
    cyc(3'b000, 1, 32'h800, 0, 1, 1, 3'b101, 0);
    cyc(3'b000, 1, 32'h804, 0, 1, 1, 3'b010, 0);
    chk("tp5_ie", 32'(ie), 32'h0);
    idle(3'b010);
    step(3'b010, 32'h808);
    step(3'b010, 32'h80c);

    // Plan 6: reset mid-service, line held high through release.
    cyc(3'b000, 1, 32'h900, 0, 1, 0, 3'b111, 0);
    idle(3'b001);
    step(3'b001, 32'ha00);
    idle(3'b101);
    step(3'b101, 32'hb00);
    idle(3'b111);
    cyc(3'b111, 0, 0, 0, 0, 0, 3'b000, 1);
    chk("tp6_reset_pending", 32'(pending), 32'h0);
    idle(3'b111);
    chk("tp6_pending_after_release", 32'(pending), 32'h7);

    // Random traffic.
    cur_irq = '0;
    for (int c = 0; c < 3000; c++) begin
      bit d, u, s, cl, r;
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) cur_irq[i] = ~cur_irq[i];
      d  = ($urandom_range(1) == 0);
      u  = ($urandom_range(5) == 0);
      s  = ($urandom_range(4) == 0);
      cl = ($urandom_range(6) == 0);
      r  = ($urandom_range(299) == 0);
      cyc(cur_irq, d, $urandom & 32'hffff_fffc, u, s, cl, N'($urandom), r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Vectored, priority-nesting user-interrupt controller for the single-cycle RISC-V core.
- Sits beside the hardwired instruction controller. It latches peripheral interrupt edges and keeps the per-source enable bits written by CSRRSI/CSRRCI.
- At instruction boundaries it decides whether to redirect the PC to a handler vector.
- It holds a return-PC stack that uret pops, which gives nested interrupts by strict priority.

Parameters:
- NUM_IRQ, 3, number of interrupt sources. Higher index means higher priority.
- PC_W, 32, PC / vector width.
- VEC_BASE, 32'h0000_1000, handler address of source 0. Source i vectors to VEC_BASE + 4*i.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  NUM_IRQ  peripheral request lines, synchronous to clk, rising-edge sensitive.
- instr_done  in  1  current instruction retires this cycle; this is the only legal interrupt boundary.
- pc_next  in  PC_W  address the core would fetch after the retiring instruction.
- uret  in  1  decoded uret of the retiring instruction.
- csrrsi  in  1  decoded CSRRSI of the retiring instruction.
- csrrci  in  1  decoded CSRRCI of the retiring instruction.
- csr_zimm  in  NUM_IRQ  low bits of the zimm field: enable-bit mask.
- irq_take  out  1  registered one-cycle pulse; the core loads irq_vector into the PC.
- irq_vector  out  PC_W  registered handler address, valid while irq_take=1.
- epc  out  PC_W  top of the return stack; the core loads it on uret. Reads 0 when the stack is empty.
- ie  out  NUM_IRQ  enable bits.
- pending  out  NUM_IRQ  latched requests.
- in_service  out  NUM_IRQ  sources currently being serviced (nested).

Behaviour:
- Reset:
  - ie, pending, in_service, irq_prev, all stack entries, stack pointer, irq_take, irq_vector are cleared to 0.
  - Reset has priority over every other input. It aborts nesting and discards pending edges.
  - A line that is already high when reset releases sets pending one cycle later, because irq_prev is 0.
- Edge capture:
  - irq_prev <= irq_in every cycle.
  - The rise condition is irq_in & ~irq_prev. A rise sets pending[i] at the next edge. The request is therefore visible 1 cycle after the rising sample.
  - pending latches regardless of ie.
- Enable update (only when instr_done=1):
  - csrrsi: ie <= ie | csr_zimm.
  - csrrci: ie <= ie & ~csr_zimm.
  - If both are asserted, clear wins (ie & ~csr_zimm).
  - The new ie takes effect for the take decision at the following instr_done, not the same one.
- Level rule: cur_level = index of the highest set in_service bit, or -1 if none.
- Candidate selection:
  - Candidate = highest index i with pending[i] & ie[i] and i > cur_level.
  - Lower or equal priority sources stay pending until service ends.
- Take (registered decision): when instr_done=1, uret=0, rst=0 and a candidate exists, on that clock edge:
  - clear pending[i];
  - set in_service[i];
  - push pc_next onto the stack and increment the stack pointer;
  - irq_vector <= VEC_BASE + 4*i;
  - irq_take <= 1.
  - irq_take returns to 0 on the next cycle.
  - At most one take per instr_done.
- Back-to-back: the cycle after a take, irq_take=1 and the core is redirecting. instr_done must be ignored for take decisions while irq_take=1; only edge capture runs.
- Return (instr_done=1 and uret=1):
  - pop the stack (epc shows the new top next cycle);
  - clear the highest set in_service bit;
  - no take is evaluated that cycle. A tail-chained candidate is taken at the next instr_done.
  - uret with an empty stack is ignored and must not underflow.
- Same-cycle rise and take on the same source: the set wins, so pending[i] stays 1 for a second service.
- Stack:
  - depth NUM_IRQ; strict priority makes overflow impossible.
  - epc is combinational from the top entry.
- State summary: the implicit FSM is RUN, TAKE (one cycle, irq_take=1), then RUN. There is no stall to the core beyond the redirect.

Test Plan:
1. Reset, then irq_in[0] rises with ie=000 -> pending=001, irq_take stays 0. Then csrrsi with zimm=001 and instr_done -> ie=001, no take that cycle. Next instr_done with pc_next=0x200 -> irq_take pulse, irq_vector=0x1000, epc=0x200, in_service=001, pending=000.
2. Nesting, while servicing irq0, ie=101: irq2 rises, instr_done with pc_next=0x1010 -> irq_vector=0x1008, epc=0x1010, in_service=101. uret+instr_done -> in_service=001, epc=0x200. Second uret -> in_service=000, epc=0.
3. While servicing irq2, irq1 rises with ie=111 -> no take through 5 instr_done cycles. uret -> next instr_done takes irq1, vector 0x1004.
4. irq1 and irq2 rise in the same cycle, ie=111 -> first take vector 0x1008. irq1 stays pending until after the irq2 uret.
5. csrrsi and csrrci both asserted with zimm=010 and ie=010 -> ie=000. A pending irq1 is not taken.
6. rst asserted mid-service with in_service=101 and pending=010 -> next cycle all outputs are 0. irq_in held high through rst release -> pending set 1 cycle after release.
